// File: rtl/vram_pkg.sv
// Shared defaults, clear-engine state encoding and address helper for the VRAM arbiter.
package vram_pkg;

    localparam int unsigned ADDR_W_DEF = 15;
    localparam int unsigned DATA_W_DEF = 12;
    localparam int unsigned DEPTH_DEF  = 19200;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    // True when a word address falls inside the populated VRAM.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/vram_clear_engine.sv
// Full-screen clear sequencer: walks addresses 0..DEPTH-1 writing a latched fill colour.
module vram_clear_engine
    import vram_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] color,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] count,
    output logic [DATA_W-1:0] fill
);

    clr_state_t state;
    clr_state_t next_state;
    logic       at_last;
    logic       load_c;
    logic       step_c;
    logic       last_c;

    assign at_last = (count == ADDR_W'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start)   next_state = CLEAR;
            CLEAR:   if (at_last) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        load_c = 1'b0;
        step_c = 1'b0;
        last_c = 1'b0;
        case (state)
            IDLE:  load_c = start;
            CLEAR: begin
                step_c = !at_last;
                last_c = at_last;
            end
            default: ;
        endcase
    end

    // Counter stops at DEPTH-1; the final write coincides with the return to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            fill  <= '0;
            done  <= 1'b0;
        end else begin
            done <= last_c;
            if (load_c) begin
                count <= '0;
                fill  <= color;
            end else if (step_c) begin
                count <= count + ADDR_W'(1);
            end
        end
    end

    assign busy = (state == CLEAR);

endmodule

// File: rtl/vram_arbiter.sv
// Two-port round-robin VRAM write arbiter with an optional full-screen clear engine.
// Define VRAM_CLEAR_EN to build the clear engine; otherwise clr_start is ignored.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    output logic              ack0,
    output logic              ack1,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_color,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] WAddr,
    output logic [DATA_W-1:0] Din,
    output logic              WE
);

    logic [ADDR_W-1:0] clr_count;
    logic [DATA_W-1:0] clr_fill;
    logic              elig0;
    logic              elig1;
    logic              grant0;
    logic              grant1;
    logic              last_gnt;
    logic              ok0;
    logic              ok1;

`ifdef VRAM_CLEAR_EN
    vram_clear_engine #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_clear (
        .clk   (clk),
        .rst   (rst),
        .start (clr_start),
        .color (clr_color),
        .busy  (clr_busy),
        .done  (clr_done),
        .count (clr_count),
        .fill  (clr_fill)
    );
`else
    logic unused_clr;
    assign unused_clr = ^{clr_start, clr_color};
    assign clr_busy   = 1'b0;
    assign clr_done   = 1'b0;
    assign clr_count  = '0;
    assign clr_fill   = '0;
`endif

    // A port whose ack is showing is still holding its finished request; skip it.
    assign elig0  = req0 && !ack0 && !clr_busy;
    assign elig1  = req1 && !ack1 && !clr_busy;
    assign grant0 = elig0 && (!elig1 || last_gnt);
    assign grant1 = elig1 && !grant0;

    assign ok0 = addr_in_range(32'(addr0), DEPTH);
    assign ok1 = addr_in_range(32'(addr1), DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            WE       <= 1'b0;
            WAddr    <= '0;
            Din      <= '0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            last_gnt <= 1'b1;
        end else begin
            ack0 <= grant0;
            ack1 <= grant1;
            if (clr_busy) begin
                WE    <= 1'b1;
                WAddr <= clr_count;
                Din   <= clr_fill;
            end else if (grant0) begin
                WE       <= ok0;
                WAddr    <= ok0 ? addr0 : '0;
                Din      <= data0;
                last_gnt <= 1'b0;
            end else if (grant1) begin
                WE       <= ok1;
                WAddr    <= ok1 ? addr1 : '0;
                Din      <= data1;
                last_gnt <= 1'b1;
            end else begin
                WE <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: vector table for port traffic plus clear/reset sequences.
module tb_vram_arbiter;

    logic        clk;
    logic        rst;
    logic        req0;
    logic        req1;
    logic [14:0] addr0;
    logic [14:0] addr1;
    logic [11:0] data0;
    logic [11:0] data1;
    logic        ack0;
    logic        ack1;
    logic        clr_start;
    logic [11:0] clr_color;
    logic        clr_busy;
    logic        clr_done;
    logic [14:0] WAddr;
    logic [11:0] Din;
    logic        WE;

    int checks = 0;
    int errors = 0;

    vram_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .addr0     (addr0),
        .addr1     (addr1),
        .data0     (data0),
        .data1     (data1),
        .ack0      (ack0),
        .ack1      (ack1),
        .clr_start (clr_start),
        .clr_color (clr_color),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .WAddr     (WAddr),
        .Din       (Din),
        .WE        (WE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req0;
        logic [14:0] addr0;
        logic [11:0] data0;
        logic        req1;
        logic [14:0] addr1;
        logic [11:0] data1;
        logic        we;
        logic [14:0] waddr;
        logic [11:0] din;
        logic        ack0;
        logic        ack1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r0, input int a0, input int d0,
                                input logic r1, input int a1, input int d1,
                                input logic we, input int wa, input int di,
                                input logic k0, input logic k1);
        vec_t v;
        v.req0 = r0; v.addr0 = 15'(a0); v.data0 = 12'(d0);
        v.req1 = r1; v.addr1 = 15'(a1); v.data1 = 12'(d1);
        v.we = we; v.waddr = 15'(wa); v.din = 12'(di);
        v.ack0 = k0; v.ack1 = k1;
        return v;
    endfunction

    task automatic check(input bit ok, input string name, input string detail);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k0;
        int k1;
        vec_t v;

        // Single-port write, held req, then drop.
        vecs.push_back(mk(1, 5, 'hF00, 0, 0, 0,   1, 5, 'hF00, 1, 0));
        vecs.push_back(mk(1, 5, 'hF00, 0, 0, 0,   0, 5, 'hF00, 0, 0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 0,   0, 5, 'hF00, 0, 0));
        // Out-of-range address: acked, no write, address masked to 0.
        vecs.push_back(mk(1, 19200, 'h0AB, 0, 0, 0, 0, 0, 'h0AB, 1, 0));
        vecs.push_back(mk(1, 19200, 'h0AB, 0, 0, 0, 0, 0, 'h0AB, 0, 0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 0,   0, 0, 'h0AB, 0, 0));
        // Port 1 alone.
        vecs.push_back(mk(0, 0, 0,  1, 7, 'h00F,  1, 7, 'h00F, 0, 1));
        vecs.push_back(mk(0, 0, 0,  1, 7, 'h00F,  0, 7, 'h00F, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0,      0, 7, 'h00F, 0, 0));
        // Two continuous requesters, four items each: writes every cycle, alternating.
        for (int r = 0; r <= 8; r++) begin
            k0 = r / 2;
            k1 = (r > 0) ? (r - 1) / 2 : 0;
            if (r == 8)
                v = mk(0, 0, 0, 1, 200 + k1, 'h200 + k1, 0, 203, 'h203, 0, 0);
            else if (r % 2 == 0)
                v = mk(1, 100 + k0, 'h100 + k0, 1, 200 + k1, 'h200 + k1,
                       1, 100 + r / 2, 'h100 + r / 2, 1, 0);
            else
                v = mk(1, 100 + k0, 'h100 + k0, 1, 200 + k1, 'h200 + k1,
                       1, 200 + (r - 1) / 2, 'h200 + (r - 1) / 2, 0, 1);
            vecs.push_back(v);
        end
        // Port 1 loses arbitration and withdraws: never written or acked.
        vecs.push_back(mk(1, 1, 'h111, 1, 2, 'h222, 1, 1, 'h111, 1, 0));
        vecs.push_back(mk(1, 1, 'h111, 0, 2, 'h222, 0, 1, 'h111, 0, 0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 0,     0, 1, 'h111, 0, 0));

        rst = 1'b1; req0 = 0; req1 = 0; addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
        clr_start = 1'b0; clr_color = '0;
        tick();
        tick();
        check(!WE && WAddr == 0 && Din == 0 && !ack0 && !ack1 && !clr_busy && !clr_done,
              "reset", $sformatf("got we=%b waddr=%0d din=%h ack0=%b ack1=%b busy=%b done=%b, need all 0",
                                 WE, WAddr, Din, ack0, ack1, clr_busy, clr_done));
        rst = 1'b0;

        foreach (vecs[i]) begin
            req0 = vecs[i].req0; addr0 = vecs[i].addr0; data0 = vecs[i].data0;
            req1 = vecs[i].req1; addr1 = vecs[i].addr1; data1 = vecs[i].data1;
            tick();
            check(WE == vecs[i].we && WAddr == vecs[i].waddr && Din == vecs[i].din &&
                  ack0 == vecs[i].ack0 && ack1 == vecs[i].ack1, $sformatf("vec%0d", i),
                  $sformatf("got we=%b waddr=%0d din=%h ack0=%b ack1=%b, need we=%b waddr=%0d din=%h ack0=%b ack1=%b",
                            WE, WAddr, Din, ack0, ack1, vecs[i].we, vecs[i].waddr, vecs[i].din,
                            vecs[i].ack0, vecs[i].ack1));
        end
        req0 = 0; req1 = 0;
        tick();

`ifdef VRAM_CLEAR_EN
        begin
            int busy_cyc = 0, writes = 0, bad = 0, exp_a = 0, early = 0;
            int done_cnt = 0, done_idx = -1, fall_idx = -1, ack_idx = -1, found = 0;
            bit ack_ok = 0;

            clr_color = 12'h0F0;
            clr_start = 1'b1;
            tick();
            clr_start = 1'b0;
            check(clr_busy && !WE, "clr_start",
                  $sformatf("got busy=%b we=%b, need busy=1 we=0", clr_busy, WE));
            for (int i = 0; i < 19400; i++) begin
                if (clr_busy) busy_cyc++;
                else if (fall_idx < 0) fall_idx = i;
                if (WE && !ack1) begin
                    writes++;
                    if (WAddr != 15'(exp_a) || Din != 12'h0F0) bad++;
                    exp_a++;
                end
                if (ack1) begin
                    if (clr_busy) early++;
                    else if (ack_idx < 0) begin
                        ack_idx = i;
                        ack_ok  = WE && WAddr == 15'd9 && Din == 12'h123;
                    end
                end
                if (clr_done) begin done_cnt++; done_idx = i; end
                if (ack_idx >= 0) break;
                if (i == 10) begin req1 = 1; addr1 = 15'd9; data1 = 12'h123; end
                if (i == 50) begin clr_start = 1; clr_color = 12'hABC; end
                else clr_start = 0;
                tick();
            end
            clr_start = 0;
            check(busy_cyc == 19200, "clr_busy_len", $sformatf("got %0d cycles, need 19200", busy_cyc));
            check(writes == 19200, "clr_writes", $sformatf("got %0d writes, need 19200", writes));
            check(bad == 0, "clr_addr_data", $sformatf("got %0d bad writes, need 0", bad));
            check(done_cnt == 1 && done_idx == fall_idx, "clr_done",
                  $sformatf("got %0d pulses at %0d (busy fell %0d), need 1 at fall", done_cnt, done_idx, fall_idx));
            check(early == 0, "req1_wait", $sformatf("got %0d acks during clear, need 0", early));
            check(ack_idx > fall_idx && ack_idx - fall_idx <= 2 && fall_idx >= 0, "req1_after",
                  $sformatf("got ack at %0d busy fell %0d, need within 2", ack_idx, fall_idx));
            check(ack_ok, "req1_write", $sformatf("got we=%b waddr=%0d din=%h, need 1/9/123", WE, WAddr, Din));
            req1 = 0;
            tick();
            check(!ack1 && !WE, "req1_once", $sformatf("got ack1=%b we=%b, need 0/0", ack1, WE));
            tick();

            // Start coinciding with a grant: the port write goes first.
            req0 = 1; addr0 = 15'd3; data0 = 12'h333;
            clr_color = 12'h055; clr_start = 1;
            tick();
            clr_start = 0;
            check(WE && WAddr == 3 && Din == 12'h333 && ack0 && clr_busy, "start_grant",
                  $sformatf("got we=%b waddr=%0d din=%h ack0=%b busy=%b, need 1/3/333/1/1",
                            WE, WAddr, Din, ack0, clr_busy));
            req0 = 0;
            tick();
            check(WE && WAddr == 0 && Din == 12'h055 && !ack0, "start_first_clr",
                  $sformatf("got we=%b waddr=%0d din=%h ack0=%b, need 1/0/055/0", WE, WAddr, Din, ack0));
            for (int i = 0; i < 200; i++) begin
                if (WE && WAddr == 15'd99) begin found = 1; break; end
                tick();
            end
            check(found == 1, "reach_100", "got no write at 99 within 200 cycles, need one");
            rst = 1;
            tick();
            rst = 0;
            check(!clr_busy && !WE && !clr_done, "abort",
                  $sformatf("got busy=%b we=%b done=%b, need 0/0/0", clr_busy, WE, clr_done));
            bad = 0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (clr_busy || clr_done || WE) bad++;
            end
            check(bad == 0, "abort_quiet", $sformatf("got %0d active cycles, need 0", bad));
        end
`else
        begin
            int bad = 0;
            clr_color = 12'h0F0;
            clr_start = 1'b1;
            tick();
            clr_start = 1'b0;
            if (clr_busy || clr_done || WE) bad++;
            for (int i = 0; i < 5; i++) begin
                tick();
                if (clr_busy || clr_done || WE) bad++;
            end
            check(bad == 0, "clr_disabled", $sformatf("got %0d active cycles, need 0", bad));
            req0 = 1; addr0 = 15'd4; data0 = 12'h444;
            tick();
            req0 = 0;
            check(WE && WAddr == 4 && Din == 12'h444 && ack0, "port_after_start",
                  $sformatf("got we=%b waddr=%0d din=%h ack0=%b, need 1/4/444/1", WE, WAddr, Din, ack0));
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, meaning VRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 12, meaning pixel width (4:4:4 RGB).
REQ-003 SHALL have parameter DEPTH, default 19200, meaning VRAM words (160x120).
REQ-004 SHALL have port clk  input  1  system clock; the block has one clock.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have ports req0/req1  input  1 each  write request from port 0/1.
REQ-007 SHALL have ports addr0/addr1  input  ADDR_W each  write address from port 0/1.
REQ-008 SHALL have ports data0/data1  input  DATA_W each  write pixel from port 0/1.
REQ-009 SHALL have ports ack0/ack1  output  1 each  one-cycle write-done pulse to port 0/1.
REQ-010 SHALL have port clr_start  input  1  one-cycle pulse that starts a full-screen clear.
REQ-011 SHALL have port clr_color  input  DATA_W  fill pixel, sampled on an accepted clr_start.
REQ-012 SHALL have port clr_busy  output  1  clear in progress.
REQ-013 SHALL have port clr_done  output  1  one-cycle pulse after the last clear write.
REQ-014 SHALL have port WAddr  output  ADDR_W  VRAM write address.
REQ-015 SHALL have port Din  output  DATA_W  VRAM write data.
REQ-016 SHALL have port WE  output  1  VRAM write enable.

Function
REQ-017 SHALL perform at most one VRAM write per cycle; WAddr, Din and WE SHALL be registered outputs.
REQ-018 SHALL use this handshake: the requester holds req, addr and data stable until ack; the arbiter grants in cycle N; WE, WAddr, Din and the matching ack are asserted in cycle N+1.
REQ-019 SHALL exclude from arbitration in cycle N+1 any port whose ack is high in cycle N+1, so a held req is never written twice.
REQ-020 SHALL arbitrate round-robin between port 0 and port 1: on simultaneous eligible requests, grant the port not granted most recently; after reset, port 0 has priority.
REQ-021 SHALL give a continuous single requester one write every 2 cycles, and give two continuous requesters alternating grants with a write every cycle.
REQ-022 SHALL drop a request deasserted before its grant without any write or ack.
REQ-023 SHALL mask WAddr to addresses below DEPTH; an addr at or above DEPTH SHALL be acked with WE held 0.
REQ-024 SHALL run a clear with states IDLE -> CLEAR -> IDLE: clr_start in IDLE latches clr_color, sets counter to 0 and asserts clr_busy the next cycle.
REQ-025 SHALL, in CLEAR, write clr_color at address counter every cycle, counting 0..DEPTH-1 without wrap; after the write at DEPTH-1, return to IDLE, drop clr_busy and pulse clr_done.
REQ-026 SHALL give the clear strict priority: during CLEAR no port is granted and pending reqs wait without being acked.
REQ-027 SHALL ignore clr_start while clr_busy is 1.
REQ-028 SHALL, on clr_start coinciding with a port grant, complete that granted write first and begin the clear in the following cycle.

Reset
REQ-029 SHALL set WE, ack0, ack1, clr_busy and clr_done to 0, set WAddr and Din to 0, set the state to IDLE and give port 0 round-robin priority at reset.
REQ-030 SHALL abort a clear on reset mid-operation, with no clr_done pulse.

Configuration
REQ-031 SHALL, with macro VRAM_CLEAR_EN defined, include the clear engine per REQ-024..REQ-028.
REQ-032 SHALL, with VRAM_CLEAR_EN undefined, keep all ports, ignore clr_start, and tie clr_busy and clr_done to 0.

Structure
REQ-033 SHALL take ADDR_W, DATA_W and DEPTH defaults and the state encoding (IDLE, CLEAR) from shared package vram_pkg.
REQ-034 SHALL implement the clear FSM and counter in sub-module vram_clear_engine, instantiated only under VRAM_CLEAR_EN.

Verification
REQ-035 SHALL cover this scenario: req0 held with addr0=5, data0=12'hF00 -> one WE cycle with WAddr=5 and Din=F00; ack0 in the same cycle; no second write.
REQ-036 SHALL cover this scenario: req0 and req1 held with 4 writes each -> writes alternate 0,1,0,1,... and 8 WE cycles occur in 8 consecutive cycles.
REQ-037 SHALL cover this scenario: clr_start with clr_color=12'h0F0 -> clr_busy for 19200 cycles, WAddr 0..19199, Din=0F0, then one clr_done pulse.
REQ-038 SHALL cover this scenario: req1 asserted during a clear -> no ack1 until clr_busy falls; then ack1 within 2 cycles.
REQ-039 SHALL cover this scenario: rst asserted at counter=100 -> clr_busy=0 and WE=0 next cycle, with no clr_done.
REQ-040 SHALL cover this scenario: req0 with addr0=19200 -> ack0 asserted with WE=0.
